// File: rtl/player_action_sched.sv
// Per-player action scheduler: buffers attack requests, sequences the attack
// engine, and applies recovery, hit-stun and KO lockout on the SCEN frame strobe.
module player_action_sched #(
  parameter int unsigned BUF_FRAMES     = 6,
  parameter int unsigned RECOVER_FRAMES = 4,
  parameter int unsigned HITSTUN_FRAMES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       atk_req,
  input  logic       hit_in,
  input  logic       ko_in,
  input  logic       contact_in,
  input  logic       attack_busy,
  input  logic       attack_active,
  output logic       attack_enable,
  output logic       attack_start,
  output logic       attack_abort,
  output logic       move_enable,
  output logic       hitbox_live,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ATTACK   = 3'd1;
  localparam logic [2:0] S_RECOVERY = 3'd2;
  localparam logic [2:0] S_HITSTUN  = 3'd3;
  localparam logic [2:0] S_KO       = 3'd4;

  localparam logic [5:0] C_BUF = 6'(BUF_FRAMES);
  localparam logic [5:0] C_REC = 6'(RECOVER_FRAMES);
  localparam logic [5:0] C_HIT = 6'(HITSTUN_FRAMES);

  logic [2:0] r_state;
  logic       r_pending;
  logic [5:0] r_age;
  logic       r_hit_pend;
  logic [5:0] r_cnt;
  logic       r_contact;
  logic       r_abort;

  logic [2:0] w_next_state;
  logic [5:0] w_next_cnt;
  logic       w_consume;
  logic       w_atk_entry;
  logic       w_lock_now;
  logic       w_lock_next;
  logic       w_atk_accept;
  logic [5:0] w_age_inc;

  // Frame-level transition; ko_in outranks a pending hit, which outranks normal flow.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_consume    = 1'b0;
    w_atk_entry  = 1'b0;
    if (SCEN) begin
      if (ko_in) begin
        w_next_state = S_KO;
      end else if (r_state != S_KO) begin
        if (r_hit_pend) begin
          w_next_state = S_HITSTUN;
          w_next_cnt   = C_HIT;
          w_consume    = 1'b1;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (r_pending) begin
                w_next_state = S_ATTACK;
                w_consume    = 1'b1;
                w_atk_entry  = 1'b1;
              end
            end
            S_ATTACK: begin
              if (!attack_busy) begin
                if (C_REC == '0) begin
                  w_next_state = S_IDLE;
                end else begin
                  w_next_state = S_RECOVERY;
                  w_next_cnt   = C_REC;
                end
              end
            end
            S_RECOVERY, S_HITSTUN: begin
              if (r_cnt <= 6'd1) begin
                w_next_state = S_IDLE;
              end else begin
                w_next_cnt = r_cnt - 6'd1;
              end
            end
            default: w_next_state = S_IDLE;
          endcase
        end
      end
    end
  end

  // A request is dropped if we are locked out now or become locked out on this edge.
  assign w_lock_now   = (r_state == S_HITSTUN) || (r_state == S_KO);
  assign w_lock_next  = SCEN && ((w_next_state == S_HITSTUN) || (w_next_state == S_KO));
  assign w_atk_accept = atk_req && !w_lock_now && !w_lock_next;
  assign w_age_inc    = r_age + 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_abort <= (r_state == S_ATTACK) && w_lock_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_age     <= '0;
    end else if (w_atk_accept) begin
      r_pending <= 1'b1;
      r_age     <= '0;
    end else if (w_consume) begin
      r_pending <= 1'b0;
      r_age     <= '0;
    end else if (SCEN && r_pending) begin
      if (w_age_inc >= C_BUF) begin
        r_pending <= 1'b0;
        r_age     <= '0;
      end else begin
        r_age <= w_age_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_pend <= 1'b0;
    end else if (hit_in) begin
      r_hit_pend <= 1'b1;
    end else if (SCEN) begin
      r_hit_pend <= 1'b0;
    end
  end

  // One contact per swing: latch holds until the next ATTACK entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_contact <= 1'b0;
    end else if (w_atk_entry) begin
      r_contact <= 1'b0;
    end else if ((r_state == S_ATTACK) && contact_in) begin
      r_contact <= 1'b1;
    end
  end

  assign attack_start  = r_pending && (r_state == S_IDLE);
  assign attack_enable = (r_state == S_IDLE) || (r_state == S_ATTACK);
  assign move_enable   = (r_state == S_IDLE) && !r_pending;
  assign hitbox_live   = attack_active && (r_state == S_ATTACK) && !r_contact;
  assign attack_abort  = r_abort;
  assign state         = r_state;

endmodule

// File: tb/tb_player_action_sched.sv
// Scoreboard bench for player_action_sched: two instances (BUF_FRAMES 6 and 2)
// driven in lockstep, each paired with a frame-level reference and engine model.
module tb_player_action_sched;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ATK  = 3'd1;
  localparam logic [2:0] ST_REC  = 3'd2;
  localparam logic [2:0] ST_HIT  = 3'd3;
  localparam logic [2:0] ST_KO   = 3'd4;
  localparam int unsigned REC_N  = 4;
  localparam int unsigned HIT_N  = 12;
  localparam int unsigned BUSY_N = 18;

  typedef struct packed {
    logic [2:0] st;
    logic       pend;
    logic [5:0] age;
    logic       hp;
    logic [5:0] cnt;
    logic       cl;
    logic       abort;
  } mdl_t;

  typedef struct packed {
    logic       busy;
    logic [5:0] frames;
  } eng_t;

  typedef struct packed {
    logic [2:0] st;
    logic       start;
    logic       en;
    logic       mv;
    logic       abort;
    logic       hb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic SCEN = 1'b0, atk_req = 1'b0, hit_in = 1'b0, ko_in = 1'b0, contact_in = 1'b0;
  logic busy [2];
  logic active [2];
  logic o_en [2];
  logic o_start [2];
  logic o_abort [2];
  logic o_mv [2];
  logic o_hb [2];
  logic [2:0] st_o [2];

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic ko_lvl = 1'b0;
  mdl_t m [2];
  eng_t e [2];
  exp_t sb_q [$];
  int   occ [2][8];
  int   abort_cnt [2];
  int   abort_at [2];
  int   hb_cnt [2];
  int   mv_low [2];

  always #5 clk = ~clk;

  player_action_sched u_dut_a (
    .clk(clk), .reset(reset), .SCEN(SCEN), .atk_req(atk_req), .hit_in(hit_in),
    .ko_in(ko_in), .contact_in(contact_in), .attack_busy(busy[0]),
    .attack_active(active[0]), .attack_enable(o_en[0]), .attack_start(o_start[0]),
    .attack_abort(o_abort[0]), .move_enable(o_mv[0]), .hitbox_live(o_hb[0]),
    .state(st_o[0])
  );

  player_action_sched #(.BUF_FRAMES(2)) u_dut_b (
    .clk(clk), .reset(reset), .SCEN(SCEN), .atk_req(atk_req), .hit_in(hit_in),
    .ko_in(ko_in), .contact_in(contact_in), .attack_busy(busy[1]),
    .attack_active(active[1]), .attack_enable(o_en[1]), .attack_start(o_start[1]),
    .attack_abort(o_abort[1]), .move_enable(o_mv[1]), .hitbox_live(o_hb[1]),
    .state(st_o[1])
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic eng_act(input eng_t c);
    return c.busy && (c.frames >= 6'd8) && (c.frames <= 6'd15);
  endfunction

  function automatic eng_t eng_next(input eng_t c, input logic sc, input logic start,
                                    input logic abort);
    eng_t n = c;
    if (sc && start) begin
      n.busy   = 1'b1;
      n.frames = 6'(BUSY_N);
    end else if (abort) begin
      n.busy   = 1'b0;
      n.frames = '0;
    end else if (sc && c.busy) begin
      n.frames = c.frames - 6'd1;
      if (n.frames == '0) n.busy = 1'b0;
    end
    return n;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t c, input int unsigned bufn, input logic sc,
                                    input logic atk, input logic hit, input logic ko,
                                    input logic contact, input logic bsy);
    mdl_t n = c;
    logic [2:0] goes = c.st;
    logic stun_hit;
    logic fire;
    logic blocked;
    stun_hit = sc && !ko && (c.st != ST_KO) && c.hp;
    fire     = sc && !ko && !c.hp && (c.st == ST_IDLE) && c.pend;
    if (sc) begin
      if (ko || c.st == ST_KO)                              goes = ST_KO;
      else if (c.hp)                                        goes = ST_HIT;
      else if (fire)                                        goes = ST_ATK;
      else if (c.st == ST_ATK && !bsy)                      goes = (REC_N == 0) ? ST_IDLE : ST_REC;
      else if ((c.st == ST_REC || c.st == ST_HIT) && c.cnt == 6'd1) goes = ST_IDLE;
    end
    if (stun_hit) n.cnt = 6'(HIT_N);
    else if (sc && c.st == ST_ATK && goes == ST_REC) n.cnt = 6'(REC_N);
    else if (sc && goes == c.st && (c.st == ST_REC || c.st == ST_HIT)) n.cnt = c.cnt - 6'd1;
    n.abort = sc && (c.st == ST_ATK) && (goes == ST_HIT || goes == ST_KO);
    if (fire) n.cl = 1'b0;
    else if (c.st == ST_ATK && contact) n.cl = 1'b1;
    n.hp = hit ? 1'b1 : (sc ? 1'b0 : c.hp);
    blocked = (c.st == ST_HIT) || (c.st == ST_KO) || (sc && (goes == ST_HIT || goes == ST_KO));
    if (atk && !blocked) begin
      n.pend = 1'b1;
      n.age  = '0;
    end else if (stun_hit || fire) begin
      n.pend = 1'b0;
      n.age  = '0;
    end else if (sc && c.pend) begin
      if (int'(c.age) + 1 == int'(bufn)) begin
        n.pend = 1'b0;
        n.age  = '0;
      end else begin
        n.age = c.age + 6'd1;
      end
    end
    n.st = goes;
    return n;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 8; s++) occ[i][s] = 0;
      abort_cnt[i] = 0;
      abort_at[i]  = -1;
      hb_cnt[i]    = 0;
      mv_low[i]    = 0;
    end
  endtask

  // Called at posedge+1; asserts reset between edges and checks outputs before any edge.
  task automatic do_reset();
    reset = 1'b1;
    SCEN = 1'b0; atk_req = 1'b0; hit_in = 1'b0; contact_in = 1'b0;
    ko_lvl = 1'b0; ko_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; active[i] = 1'b0;
      m[i] = '0; e[i] = '0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_state", i), int'(st_o[i]), int'(ST_IDLE));
      chk($sformatf("rst%0d_outs", i),
          int'({o_start[i], o_en[i], o_mv[i], o_abort[i], o_hb[i]}), int'(5'b01100));
    end
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic tick(input logic atk, input logic hit, input logic contact);
    logic sc;
    exp_t x;
    mdl_t nm;
    logic act_v;
    logic [7:0] got;
    sc = (cyc % 8 == 7);
    SCEN = sc; atk_req = atk; hit_in = hit; contact_in = contact; ko_in = ko_lvl;
    for (int i = 0; i < 2; i++) begin
      act_v     = eng_act(e[i]);
      busy[i]   = e[i].busy;
      active[i] = act_v;
      nm = mdl_next(m[i], (i == 0) ? 6 : 2, sc, atk, hit, ko_lvl, contact, e[i].busy);
      x.st    = nm.st;
      x.start = nm.pend && (nm.st == ST_IDLE);
      x.en    = (nm.st == ST_IDLE) || (nm.st == ST_ATK);
      x.mv    = (nm.st == ST_IDLE) && !nm.pend;
      x.abort = nm.abort;
      x.hb    = act_v && (nm.st == ST_ATK) && !nm.cl;
      sb_q.push_back(x);
      e[i] = eng_next(e[i], sc, m[i].pend && (m[i].st == ST_IDLE), m[i].abort);
      m[i] = nm;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      x   = sb_q.pop_front();
      got = {st_o[i], o_start[i], o_en[i], o_mv[i], o_abort[i], o_hb[i]};
      chk($sformatf("sb%0d_c%0d", i, cyc), int'(got), int'(x));
      if (st_o[i] < 3'd5) occ[i][st_o[i]]++;
      if (o_abort[i]) begin
        abort_cnt[i]++;
        abort_at[i] = cyc;
      end
      if (o_hb[i]) hb_cnt[i]++;
      if (!o_mv[i]) mv_low[i]++;
    end
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    clear_stats();

    // Basic attack: request at cycle 3, engine busy 18 frames
    do_reset(); clear_stats();
    run_to(3); tick(1'b1, 1'b0, 1'b0);
    run_to(260);
    chk("s1_attack_cycles", occ[0][1], 152);
    chk("s1_recovery_cycles", occ[0][2], 32);
    chk("s1_move_low_cycles", mv_low[0], 188);
    chk("s1_b_attack_cycles", occ[1][1], 152);

    // Request buffered during recovery frame 2
    do_reset(); clear_stats();
    run_to(3); tick(1'b1, 1'b0, 1'b0);
    run_to(170); tick(1'b1, 1'b0, 1'b0);
    run_to(205);
    chk("s2_buf6_state", int'(st_o[0]), int'(ST_ATK));
    chk("s2_buf2_state", int'(st_o[1]), int'(ST_IDLE));
    chk("s2_buf2_start", int'(o_start[1]), 0);

    // Hit during attack, then combo hit during stun
    do_reset(); clear_stats();
    run_to(3); tick(1'b1, 1'b0, 1'b0);
    run_to(42); tick(1'b0, 1'b1, 1'b0);
    run_to(106); tick(1'b0, 1'b1, 1'b0);
    run_to(230);
    chk("s3_stun_cycles", occ[0][3], 160);
    chk("s3_abort_count", abort_cnt[0], 1);
    chk("s3_abort_cycle", abort_at[0], 47);
    chk("s3_end_state", int'(st_o[0]), int'(ST_IDLE));

    // Two contacts in one swing, then a fresh swing re-arms the hitbox
    do_reset(); clear_stats();
    run_to(3); tick(1'b1, 1'b0, 1'b0);
    run_to(40); tick(1'b0, 1'b0, 1'b1);
    run_to(60); tick(1'b0, 1'b0, 1'b1);
    run_to(260);
    chk("s4_hitbox_first", hb_cnt[0], 8);
    tick(1'b1, 1'b0, 1'b0);
    run_to(420);
    chk("s4_hitbox_total", hb_cnt[0], 72);

    // KO together with pending hit and pending request
    do_reset(); clear_stats();
    run_to(2); tick(1'b1, 1'b0, 1'b0);
    run_to(4); tick(1'b0, 1'b1, 1'b0);
    ko_lvl = 1'b1;
    run_to(8);
    chk("s5_state", int'(st_o[0]), int'(ST_KO));
    chk("s5_enables", int'({o_en[0], o_mv[0], o_start[0]}), 0);
    ko_lvl = 1'b0;
    run_to(100); tick(1'b1, 1'b0, 1'b0);
    run_to(120);
    chk("s5_still_ko", int'(st_o[0]), int'(ST_KO));
    chk("s5_b_still_ko", int'(st_o[1]), int'(ST_KO));

    // Reset in the middle of hit-stun
    do_reset(); clear_stats();
    run_to(3); tick(1'b0, 1'b1, 1'b0);
    run_to(30);
    chk("s6_pre_state", int'(st_o[0]), int'(ST_HIT));
    do_reset();
    run_to(40);
    chk("s6_abort_count", abort_cnt[0], 0);
    chk("s6_post_state", int'(st_o[0]), int'(ST_IDLE));

    // Random pulses against the reference model
    do_reset(); clear_stats();
    for (int k = 0; k < 1500; k++) begin
      tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/player_action_sched.md
# player_action_sched

Per-player action scheduler that sequences the attack timing engine and gates movement. It buffers attack requests and issues a start to the attack engine only when that engine can accept one. It applies post-attack recovery, hit-stun and KO lockout, and gates the hitbox so one swing registers at most one contact. One instance sits per player, between the input-cleaning logic and the attack/movement engines, and runs on the same one-pulse-per-frame SCEN strobe.

## Interface
- BUF_FRAMES, 6: frames a buffered attack request stays valid (1..63)
- RECOVER_FRAMES, 4: lockout frames after an attack ends (0..63; 0 = none)
- HITSTUN_FRAMES, 12: stun frames per received hit (1..63)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- SCEN  in  1  frame strobe, one clk cycle per frame
- atk_req  in  1  cleaned attack request pulse, any clk cycle
- hit_in  in  1  "this player was hit" pulse, any clk cycle
- ko_in  in  1  level; health exhausted
- contact_in  in  1  pulse; this player's hitbox touched opponent
- attack_busy  in  1  from attack engine
- attack_active  in  1  from attack engine
- attack_enable  out  1  to attack engine
- attack_start  out  1  to attack engine trigger input
- attack_abort  out  1  one-clk pulse; clears attack engine
- move_enable  out  1  to movement engine
- hitbox_live  out  1  gated hitbox to collision logic
- state  out  3  IDLE=0, ATTACK=1, RECOVERY=2, HITSTUN=3, KO=4

## Operation
- Request latch: an atk_req in any clk cycle sets pending and clears age, including a re-press while pending. On each SCEN, age is incremented while pending. pending clears when age reaches BUF_FRAMES. An atk_req in HITSTUN or KO is discarded.
- Hit latch: a hit_in in any clk cycle sets hit_pend. hit_pend is consumed on the next SCEN.
- All state transitions occur only on clk edges with SCEN=1. Priority: ko_in > hit_pend > normal flow.
- IDLE: if pending, go to ATTACK, clear pending, and clear the contact latch.
- ATTACK: if attack_busy=0 on an SCEN, go to RECOVERY with cnt=RECOVER_FRAMES. If RECOVER_FRAMES=0, go directly to IDLE instead.
  - The first SCEN after entering ATTACK must observe attack_busy=1, because the engine sets busy on the same edge.
- RECOVERY: decrement cnt on each SCEN. When cnt reaches 1, go to IDLE. Residency is exactly RECOVER_FRAMES frames.
- hit_pend on SCEN in IDLE, ATTACK, RECOVERY or HITSTUN: go to HITSTUN, load cnt=HITSTUN_FRAMES, clear pending and hit_pend.
  - A hit while in HITSTUN reloads cnt (combo).
  - If leaving ATTACK this way, pulse attack_abort.
- HITSTUN: decrement cnt on each SCEN. When cnt reaches 1, go to IDLE.
- ko_in=1 on SCEN in any state: go to KO. If leaving ATTACK, pulse attack_abort. KO is exited only by reset.
- Contact latch: set by contact_in while in ATTACK; cleared on entry to ATTACK.
- Combinational outputs from registered state:
  - attack_start = pending && state==IDLE
  - attack_enable = state∈{IDLE,ATTACK}
  - move_enable = state==IDLE && !pending
  - hitbox_live = attack_active && state==ATTACK && !contact_latch
- Counters (cnt, age) are 6-bit and never wrap. The decrement stops at the exit condition.

## Timing
- Reset values: state=IDLE, pending=0, hit_pend=0, age=0, cnt=0, contact_latch=0, attack_abort=0.
  - Output values at reset: attack_enable=1, move_enable=1, attack_start=0, hitbox_live=0.
- Buffered-start latency: attack_start asserts the cycle after atk_req if in IDLE. The engine trigger and the ATTACK entry then coincide on the next SCEN edge.
- attack_abort is registered: high exactly one clk cycle, starting the cycle after the SCEN edge that leaves ATTACK.
- Simultaneous events on the same SCEN:
  - hit_pend together with pending in IDLE: HITSTUN wins and no attack_start is consumed.
  - atk_req on the SCEN cycle itself is latched and becomes effective on the next SCEN.
- A request buffered during ATTACK or RECOVERY fires from IDLE on the first SCEN after returning to IDLE, if it is still within BUF_FRAMES.
- contact_in in the same cycle as attack_active: hitbox_live drops on the following cycle.
- Asynchronous reset mid-operation returns to the reset values immediately, regardless of SCEN.

## Test plan
- IDLE, atk_req at cycle 3, SCEN every 8 cycles with engine model (busy 18 frames) -> state=ATTACK at first SCEN; RECOVERY 4 frames after busy falls; IDLE after that; move_enable=0 throughout.
- atk_req during RECOVERY frame 2, RECOVER_FRAMES=4 -> attack starts on the first SCEN in IDLE. Same with BUF_FRAMES=2 -> request expires and stays IDLE.
- hit_in during ATTACK frame 5 -> HITSTUN on next SCEN; one-cycle attack_abort; IDLE after 12 frames. Second hit_in at stun frame 8 -> 12 more frames.
- Two contact_in pulses within the active window -> hitbox_live drops after the first and stays 0 until the next ATTACK entry.
- ko_in with hit_pend and pending on the same SCEN -> KO; all enables 0; stays KO until reset.
- reset asserted mid-HITSTUN between SCENs -> immediate IDLE; attack_enable=1 and move_enable=1; no abort pulse.
